mac_rx_frame: RTL
=================

Name: mac_rx_frame

Overview:
- Receive-side counterpart of the MAC TX path; GMII-style byte stream in, upper-layer payload stream out.
- Strips preamble and SFD, filters on destination MAC, classifies the EtherType (IP/ARP), and strips the FCS.
- Checks CRC-32 and reports a per-frame good/error status.
- Feeds the IP RX and ARP RX blocks, mirroring how the IP TX and ARP TX blocks feed the MAC TX path.

Parameters:
- PREAMBLE_MIN, 4: minimum count of 0x55 bytes required before SFD 0xD5.
- MAX_FRAME_LEN, 1518: maximum bytes counted from destination MAC through FCS.
- MIN_FRAME_LEN, 64: minimum bytes counted from destination MAC through FCS.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous reset, active-high.
- mac_rx_dv  in  1  receive data valid; high for the whole frame, including preamble.
- mac_rx_data  in  8  receive byte.
- local_mac_addr  in  48  own MAC address.
- rx_payload_valid  out  1  rx_payload_data is valid this cycle.
- rx_payload_data  out  8  payload byte; FCS is never forwarded.
- rx_frame_type  out  2  01 = IP (0x0800), 10 = ARP (0x0806); held from the TYPE state to the next frame.
- rx_source_mac_addr  out  48  source MAC of the current frame; held like rx_frame_type.
- rx_payload_length  out  16  forwarded payload byte count; valid with rx_frame_end.
- rx_frame_end  out  1  one-cycle pulse; marks end of frame.
- rx_frame_good  out  1  qualifies rx_frame_end: CRC correct and length legal.
- rx_crc_error  out  1  qualifies rx_frame_end: CRC mismatch.
- rx_len_error  out  1  qualifies rx_frame_end: runt, oversize, or dv dropped in the header.

Behaviour:
- Reset values: all outputs 0 and state IDLE.
- Reset mid-frame: the frame is abandoned, no end pulse is issued, and the block resyncs at the next dv assertion.
- States: IDLE, PREAMBLE, DEST, SRC, TYPE, DATA, DROP.
- IDLE: dv=1 with byte 0x55 -> PREAMBLE, preamble count=1. Any other byte with dv=1 -> DROP.
- PREAMBLE:
  - 0x55 -> count++ (saturates at 7).
  - 0xD5 with count >= PREAMBLE_MIN -> DEST.
  - Any other byte -> DROP.
  - dv=0 -> IDLE silently.
- DEST: 6 bytes, MSB first. Match if equal to local_mac_addr or FF:FF:FF:FF:FF:FF, evaluated on the 6th byte. Mismatch -> DROP with no end pulse.
- SRC: 6 bytes into a shadow register; copied to rx_source_mac_addr on entry to DATA.
- TYPE: 2 bytes. 0x0800 or 0x0806 -> DATA with rx_frame_type updated. Any other type -> DROP with no end pulse.
- DATA, FCS stripping: each incoming byte goes into a 4-byte delay line. rx_payload_valid asserts only when a 5th byte pushes the oldest byte out, so the final 4 bytes (FCS) are never emitted. Payload latency = 4 received bytes.
- DATA end of frame (dv falls): rx_frame_end pulses the cycle after the first dv=0, together with exactly one of rx_frame_good, rx_crc_error or rx_len_error. State -> IDLE.
- Error priority: len > crc.
- DATA oversize: frame byte count (dest through FCS) exceeding MAX_FRAME_LEN -> DROP. rx_len_error plus end pulse are issued when dv falls.
- Runt: frame byte count below MIN_FRAME_LEN at dv fall -> rx_len_error.
- dv=0 during DEST/SRC/TYPE after address match -> end pulse with rx_len_error.
- DROP: wait for dv=0, then IDLE. Outputs stay quiet apart from the oversize case above.
- CRC:
  - Covers destination through FCS inclusive.
  - Register is initialised to 0xFFFFFFFF on SFD detection.
  - Reflected polynomial 0xEDB88320, LSB-first per byte.
  - Frame is good when register == 0xDEBB20E3 after the last FCS byte.
- Frame byte counter: 11-bit, saturating.
- rx_payload_length: 16-bit count of forwarded bytes.
- Back-to-back frames: a 1-cycle dv-low gap is sufficient. The end pulse for frame N may coincide with the first preamble byte of frame N+1; both must be handled.

Decomposition:
- Shared package mac_rx_pkg: state encoding, ETH_TYPE_IP=16'h0800, ETH_TYPE_ARP=16'h0806, BCAST_MAC, CRC_POLY_REFL=32'hEDB88320, CRC_RESIDUE=32'hDEBB20E3, FRAME_TYPE_IP/ARP codes.
- Sub-module mac_rx_crc32: byte-wide CRC-32 next-state register with sync init and enable inputs and a residue_ok output.

Test Plan:
- Good ARP frame to broadcast: 8-byte preamble+SFD, 60-byte frame + valid FCS -> 46 valid bytes equal to sent payload, type=10, length=46, good=1.
- IP frame to local_mac_addr 00:0A:35:01:02:03 with 100-byte payload -> type=01, source MAC captured, 100 bytes out, no FCS bytes leak, good=1.
- Same IP frame with one payload bit flipped -> all payload forwarded, end pulse with crc_error=1, good=0.
- Destination 00:0A:35:01:02:04 (mismatch), and separately EtherType 0x86DD -> zero valid beats, no end pulse.
- 40-byte runt frame -> len_error=1. Then a 1520-byte frame -> len_error=1 and no further payload after 1518.
- Assert rst during DATA of frame 1, then send frame 2 with 1-cycle gap after rst release -> no end pulse for frame 1, frame 2 good=1. Also cover two frames with a 1-cycle dv gap -> two end pulses, both good.

Source files
------------

// File: rtl/mac_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mac_rx_pkg
//  Description : Shared types and constants for the MAC receive path:
//                parser state encoding, EtherType and frame-type codes,
//                broadcast address and CRC-32 constants plus a byte-wide
//                reflected CRC-32 update function.
//  Revision    : 1.0  initial release
// ============================================================================
package mac_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_DEST     = 3'd2,
        ST_SRC      = 3'd3,
        ST_TYPE     = 3'd4,
        ST_DATA     = 3'd5,
        ST_DROP     = 3'd6
    } rx_state_e;

    localparam logic [15:0] ETH_TYPE_IP    = 16'h0800;
    localparam logic [15:0] ETH_TYPE_ARP   = 16'h0806;
    localparam logic [47:0] BCAST_MAC      = 48'hFFFF_FFFF_FFFF;

    localparam logic [1:0]  FRAME_TYPE_IP  = 2'b01;
    localparam logic [1:0]  FRAME_TYPE_ARP = 2'b10;

    localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE       = 8'hD5;

    localparam logic [31:0] CRC_POLY_REFL  = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE    = 32'hDEBB_20E3;
    localparam logic [31:0] CRC_INIT       = 32'hFFFF_FFFF;

    // One byte of reflected CRC-32, bits consumed LSB first.
    function automatic logic [31:0] crc32_next(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage : mac_rx_pkg
`default_nettype wire

// File: rtl/mac_rx_crc32.sv
`default_nettype none
// ============================================================================
//  Module      : mac_rx_crc32
//  Description : Byte-wide CRC-32 accumulator. init_i reloads the seed,
//                en_i folds data_i into the register. residue_ok_o is high
//                when the register holds the good-frame residue, i.e. after
//                the FCS of an intact frame has been absorbed.
//  Revision    : 1.0  initial release
// ============================================================================
module mac_rx_crc32
    import mac_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       init_i,
    input  logic       en_i,
    input  logic [7:0] data_i,
    output logic       residue_ok_o
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    // Next CRC value: seeding wins over accumulation.
    always_comb begin
        crc_d = crc_q;
        if (init_i) begin
            crc_d = CRC_INIT;
        end else if (en_i) begin
            crc_d = crc32_next(crc_q, data_i);
        end
    end

    // CRC state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign residue_ok_o = (crc_q == CRC_RESIDUE);

endmodule : mac_rx_crc32
`default_nettype wire

// File: rtl/mac_rx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : mac_rx_frame
//  Description : GMII-style MAC receive parser. Strips preamble/SFD,
//                filters on destination MAC, classifies IP/ARP EtherType,
//                forwards payload with the FCS stripped through a 4-byte
//                delay line, and reports per-frame CRC/length status.
//  Revision    : 1.0  initial release
// ============================================================================
module mac_rx_frame
    import mac_rx_pkg::*;
#(
    parameter int PREAMBLE_MIN  = 4,
    parameter int MAX_FRAME_LEN = 1518,
    parameter int MIN_FRAME_LEN = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mac_rx_dv,
    input  logic [7:0]  mac_rx_data,
    input  logic [47:0] local_mac_addr,
    output logic        rx_payload_valid,
    output logic [7:0]  rx_payload_data,
    output logic [1:0]  rx_frame_type,
    output logic [47:0] rx_source_mac_addr,
    output logic [15:0] rx_payload_length,
    output logic        rx_frame_end,
    output logic        rx_frame_good,
    output logic        rx_crc_error,
    output logic        rx_len_error
);

    localparam logic [2:0]  c_pre_min = 3'(PREAMBLE_MIN);
    localparam logic [2:0]  c_pre_sat = 3'd7;
    localparam logic [10:0] c_max_len = 11'(MAX_FRAME_LEN);
    localparam logic [10:0] c_min_len = 11'(MIN_FRAME_LEN);
    localparam logic [10:0] c_cnt_sat = 11'h7FF;
    localparam logic [2:0]  c_dly_len = 3'd4;

    rx_state_e   state_q,     state_d;
    logic [2:0]  pre_cnt_q,   pre_cnt_d;
    logic [2:0]  hdr_idx_q,   hdr_idx_d;
    logic [39:0] dest_q,      dest_d;
    logic [47:0] src_q,       src_d;
    logic [7:0]  type_hi_q,   type_hi_d;
    logic [7:0]  dly_q [4];
    logic [7:0]  dly_d [4];
    logic [2:0]  fill_q,      fill_d;
    logic [10:0] byte_cnt_q,  byte_cnt_d;
    logic        oversize_q,  oversize_d;

    logic        pv_q,        pv_d;
    logic [7:0]  pd_q,        pd_d;
    logic [1:0]  ftype_q,     ftype_d;
    logic [47:0] smac_q,      smac_d;
    logic [15:0] plen_q,      plen_d;
    logic        fend_q,      fend_d;
    logic        fgood_q,     fgood_d;
    logic        fcrc_q,      fcrc_d;
    logic        flen_q,      flen_d;

    logic        w_crc_init;
    logic        w_crc_en;
    logic        w_crc_ok;
    logic [47:0] w_dest_full;
    logic        w_dest_hit;
    logic [15:0] w_type_full;
    logic [10:0] w_byte_cnt_inc;

    assign w_dest_full    = {dest_q, mac_rx_data};
    assign w_dest_hit     = (w_dest_full == local_mac_addr) || (w_dest_full == BCAST_MAC);
    assign w_type_full    = {type_hi_q, mac_rx_data};
    assign w_byte_cnt_inc = (byte_cnt_q == c_cnt_sat) ? byte_cnt_q : byte_cnt_q + 11'd1;

    mac_rx_crc32 u_crc (
        .clk          (clk),
        .rst          (rst),
        .init_i       (w_crc_init),
        .en_i         (w_crc_en),
        .data_i       (mac_rx_data),
        .residue_ok_o (w_crc_ok)
    );

    // Parser next-state, datapath updates and per-cycle output pulses.
    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        hdr_idx_d  = hdr_idx_q;
        dest_d     = dest_q;
        src_d      = src_q;
        type_hi_d  = type_hi_q;
        dly_d      = dly_q;
        fill_d     = fill_q;
        byte_cnt_d = byte_cnt_q;
        oversize_d = oversize_q;
        pv_d       = 1'b0;
        pd_d       = pd_q;
        ftype_d    = ftype_q;
        smac_d     = smac_q;
        plen_d     = plen_q;
        fend_d     = 1'b0;
        fgood_d    = 1'b0;
        fcrc_d     = 1'b0;
        flen_d     = 1'b0;
        w_crc_init = 1'b0;
        w_crc_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mac_rx_dv) begin
                    if (mac_rx_data == PREAMBLE_BYTE) begin
                        state_d   = ST_PREAMBLE;
                        pre_cnt_d = 3'd1;
                    end else begin
                        state_d   = ST_DROP;
                    end
                end
            end

            ST_PREAMBLE: begin
                if (!mac_rx_dv) begin
                    state_d = ST_IDLE;
                end else if (mac_rx_data == PREAMBLE_BYTE) begin
                    if (pre_cnt_q != c_pre_sat) begin
                        pre_cnt_d = pre_cnt_q + 3'd1;
                    end
                end else if ((mac_rx_data == SFD_BYTE) && (pre_cnt_q >= c_pre_min)) begin
                    state_d    = ST_DEST;
                    hdr_idx_d  = 3'd0;
                    byte_cnt_d = 11'd0;
                    plen_d     = 16'd0;
                    w_crc_init = 1'b1;
                end else begin
                    state_d = ST_DROP;
                end
            end

            // Before the address is known to be ours a short frame is
            // silently discarded.
            ST_DEST: begin
                if (!mac_rx_dv) begin
                    state_d = ST_IDLE;
                end else begin
                    w_crc_en   = 1'b1;
                    byte_cnt_d = w_byte_cnt_inc;
                    dest_d     = w_dest_full[39:0];
                    if (hdr_idx_q == 3'd5) begin
                        hdr_idx_d = 3'd0;
                        state_d   = w_dest_hit ? ST_SRC : ST_DROP;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 3'd1;
                    end
                end
            end

            ST_SRC: begin
                if (!mac_rx_dv) begin
                    state_d = ST_IDLE;
                    fend_d  = 1'b1;
                    flen_d  = 1'b1;
                end else begin
                    w_crc_en   = 1'b1;
                    byte_cnt_d = w_byte_cnt_inc;
                    src_d      = {src_q[39:0], mac_rx_data};
                    if (hdr_idx_q == 3'd5) begin
                        hdr_idx_d = 3'd0;
                        state_d   = ST_TYPE;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 3'd1;
                    end
                end
            end

            ST_TYPE: begin
                if (!mac_rx_dv) begin
                    state_d = ST_IDLE;
                    fend_d  = 1'b1;
                    flen_d  = 1'b1;
                end else begin
                    w_crc_en   = 1'b1;
                    byte_cnt_d = w_byte_cnt_inc;
                    if (hdr_idx_q == 3'd0) begin
                        type_hi_d = mac_rx_data;
                        hdr_idx_d = 3'd1;
                    end else if (w_type_full == ETH_TYPE_IP || w_type_full == ETH_TYPE_ARP) begin
                        state_d = ST_DATA;
                        ftype_d = (w_type_full == ETH_TYPE_IP) ? FRAME_TYPE_IP : FRAME_TYPE_ARP;
                        smac_d  = src_q;
                        fill_d  = 3'd0;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
            end

            // Payload bytes only leave the delay line once four newer bytes
            // are behind them, so the trailing FCS is never forwarded.
            ST_DATA: begin
                if (!mac_rx_dv) begin
                    state_d = ST_IDLE;
                    fend_d  = 1'b1;
                    if (byte_cnt_q < c_min_len) begin
                        flen_d = 1'b1;
                    end else if (w_crc_ok) begin
                        fgood_d = 1'b1;
                    end else begin
                        fcrc_d = 1'b1;
                    end
                end else if (byte_cnt_q >= c_max_len) begin
                    state_d    = ST_DROP;
                    oversize_d = 1'b1;
                end else begin
                    w_crc_en   = 1'b1;
                    byte_cnt_d = w_byte_cnt_inc;
                    for (int i = 0; i < 3; i++) begin
                        dly_d[i] = dly_q[i + 1];
                    end
                    dly_d[3] = mac_rx_data;
                    if (fill_q == c_dly_len) begin
                        pv_d   = 1'b1;
                        pd_d   = dly_q[0];
                        plen_d = plen_q + 16'd1;
                    end else begin
                        fill_d = fill_q + 3'd1;
                    end
                end
            end

            // Oversize frames still report their end once dv falls.
            ST_DROP: begin
                if (!mac_rx_dv) begin
                    state_d    = ST_IDLE;
                    oversize_d = 1'b0;
                    if (oversize_q) begin
                        fend_d = 1'b1;
                        flen_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pre_cnt_q  <= 3'd0;
            hdr_idx_q  <= 3'd0;
            dest_q     <= 40'd0;
            src_q      <= 48'd0;
            type_hi_q  <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                dly_q[i] <= 8'd0;
            end
            fill_q     <= 3'd0;
            byte_cnt_q <= 11'd0;
            oversize_q <= 1'b0;
            pv_q       <= 1'b0;
            pd_q       <= 8'd0;
            ftype_q    <= 2'd0;
            smac_q     <= 48'd0;
            plen_q     <= 16'd0;
            fend_q     <= 1'b0;
            fgood_q    <= 1'b0;
            fcrc_q     <= 1'b0;
            flen_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            hdr_idx_q  <= hdr_idx_d;
            dest_q     <= dest_d;
            src_q      <= src_d;
            type_hi_q  <= type_hi_d;
            dly_q      <= dly_d;
            fill_q     <= fill_d;
            byte_cnt_q <= byte_cnt_d;
            oversize_q <= oversize_d;
            pv_q       <= pv_d;
            pd_q       <= pd_d;
            ftype_q    <= ftype_d;
            smac_q     <= smac_d;
            plen_q     <= plen_d;
            fend_q     <= fend_d;
            fgood_q    <= fgood_d;
            fcrc_q     <= fcrc_d;
            flen_q     <= flen_d;
        end
    end

    assign rx_payload_valid   = pv_q;
    assign rx_payload_data    = pd_q;
    assign rx_frame_type      = ftype_q;
    assign rx_source_mac_addr = smac_q;
    assign rx_payload_length  = plen_q;
    assign rx_frame_end       = fend_q;
    assign rx_frame_good      = fgood_q;
    assign rx_crc_error       = fcrc_q;
    assign rx_len_error       = flen_q;

endmodule : mac_rx_frame
`default_nettype wire
